// File: rtl/lc3b_types.sv
// Shared LC-3b core types.
// The instruction-queue entry record and the queue depth live here so that the
// fetch, queue and dispatch stages all use one definition.
package lc3b_types;

  // Default instruction-queue depth shared by fetch and dispatch.
  localparam int IQUEUE_DEPTH = 8;

  // One fetched instruction as it travels from fetch to dispatch (49 bits).
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        prediction;
    logic [15:0] prediction_pc;
  } lc3b_iqueue_entry;

endpackage

// File: rtl/lc3b_iqueue.sv
// lc3b_iqueue: circular instruction FIFO between fetch and dispatch.
// head/tail carry an extra wrap bit so that full and empty can be told apart
// without a separate counter; occupancy is derived as tail - head.
// A flush (ROB misprediction recovery) empties the queue in one cycle.
// Optional feature: define LC3B_IQUEUE_BYPASS_EN to let an entry pass straight
// from enq_* to deq_* while the queue is empty (zero-cycle latency).
module lc3b_iqueue
  import lc3b_types::*;
#(
  parameter int DEPTH = IQUEUE_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enq_valid,
  input  lc3b_iqueue_entry             enq_entry,
  output logic                         enq_ready,
  output logic                         deq_valid,
  output lc3b_iqueue_entry             deq_entry,
  input  logic                         deq_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [PW-1:0]    head_nxt_s;
  logic [PW-1:0]    tail_nxt_s;
  logic [PW-1:0]    occ_s;
  lc3b_iqueue_entry mem_r [DEPTH];

  logic empty_s;
  logic full_s;
  logic bypass_s;
  logic enq_fire_s;
  logic deq_fire_s;

  // Status flags and fire conditions, all derived from the registered pointers.
  always_comb begin
    empty_s = (head_r == tail_r);
    full_s  = (head_r[IW] != tail_r[IW]) && (head_r[IW-1:0] == tail_r[IW-1:0]);
    occ_s   = tail_r - head_r;
`ifdef LC3B_IQUEUE_BYPASS_EN
    // An entry handed straight to a ready dispatch on an empty queue is never stored.
    bypass_s = empty_s && !flush && enq_valid && deq_ready;
`else
    bypass_s = 1'b0;
`endif
    enq_fire_s = enq_valid && !full_s && !bypass_s;
    deq_fire_s = !empty_s && deq_ready;
  end

  // Next pointer values; flush overrides any same-cycle enqueue or dequeue.
  always_comb begin
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    if (flush) begin
      head_nxt_s = '0;
      tail_nxt_s = '0;
    end else begin
      if (deq_fire_s) begin
        head_nxt_s = head_r + PW'(1);
      end else begin
        head_nxt_s = head_r;
      end
      if (enq_fire_s) begin
        tail_nxt_s = tail_r + PW'(1);
      end else begin
        tail_nxt_s = tail_r;
      end
    end
  end

  // Pointer registers; modulo-2*DEPTH wrap falls out of the natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_r <= '0;
      tail_r <= '0;
    end else begin
      head_r <= head_nxt_s;
      tail_r <= tail_nxt_s;
    end
  end

  // Entry storage; written only on an accepted, non-flushed, non-bypassed enqueue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (enq_fire_s && !flush) begin
      mem_r[tail_r[IW-1:0]] <= enq_entry;
    end
  end

  // Handshake/occupancy outputs; none of these look at the inputs.
  always_comb begin
    enq_ready = !full_s;
    count     = CW'(occ_s);
  end

  // Head presentation; on an empty queue the bypass build forwards the fetch entry.
  always_comb begin
    deq_valid = !empty_s;
    deq_entry = mem_r[head_r[IW-1:0]];
`ifdef LC3B_IQUEUE_BYPASS_EN
    if (empty_s && !flush) begin
      deq_valid = enq_valid;
      deq_entry = enq_entry;
    end else begin
      deq_valid = !empty_s;
      deq_entry = mem_r[head_r[IW-1:0]];
    end
`endif
  end

endmodule

// File: doc/lc3b_iqueue.md
# lc3b_iqueue

Instruction queue between fetch and dispatch in the LC-3b out-of-order core. It buffers fetched instructions as `lc3b_iqueue_entry` records (pc, instruction, prediction, prediction_pc) in a circular FIFO. It presents them in program order to the dispatch stage that fills reservation stations and the ROB, and it is cleared in one cycle when the ROB commits a mispredicted control-flow instruction.

## Interface
- `DEPTH`, default 8: number of entries; power of two, at least 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enq_valid`  in  1  fetch presents an entry this cycle.
- `enq_entry`  in  49 (`lc3b_iqueue_entry`)  entry to enqueue.
- `enq_ready`  out  1  queue can accept; high iff count < DEPTH.
- `deq_valid`  out  1  head entry valid for dispatch.
- `deq_entry`  out  49 (`lc3b_iqueue_entry`)  head entry.
- `deq_ready`  in  1  dispatch consumes the head this cycle.
- `flush`  in  1  discard all entries (ROB misprediction recovery).
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage is DEPTH registers of `lc3b_iqueue_entry`.
- `head` and `tail` pointers are each $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - Empty: head == tail.
  - Full: index bits equal and wrap bits differ.
- Enqueue fires when `enq_valid && enq_ready`: write `enq_entry` at tail[index], then tail+1.
- Dequeue fires when `deq_valid && deq_ready`: head+1.
- `deq_entry` is driven combinationally from storage[head[index]]. It holds stable while `deq_valid && !deq_ready`.
- Enqueue and dequeue in the same cycle are both legal, including when full. `enq_ready` does not depend on `deq_ready`, so a full queue refuses enqueue even if the head leaves that cycle.
- Wrap-around: pointers increment modulo 2·DEPTH; there is no special case at the last index.
- `count` = tail − head (modulo 2·DEPTH, zero-extended). It is registered-consistent with the pointers.
- `flush` has priority over everything. Next state is head = tail = 0 and count = 0. Same-cycle enqueue and dequeue are ignored, and the dequeue does not count as consumed. `enq_ready` still reflects the pre-flush count during the flush cycle; fetch must not rely on an enqueue in a flush cycle.
- Protocol rules:
  - Dequeue with `deq_valid` low: no effect.
  - Enqueue with `enq_ready` low: no effect; the entry is dropped and fetch must hold it.

## Timing
- Reset (`reset_n` low, asynchronous): head = tail = 0, all storage zeroed.
  - Outputs: `deq_valid` = 0, `deq_entry` = 0, `enq_ready` = 1, `count` = 0.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Latency: an entry enqueued at edge N is visible on `deq_*` after edge N (that is, in cycle N+1). No same-cycle pass-through unless the macro below is enabled.
- Throughput: one enqueue and one dequeue per cycle sustained.
- `enq_ready`, `deq_valid` and `count` are functions of registered state only, so there is no combinational path from inputs to them.

## Configuration
- `LC3B_IQUEUE_BYPASS_EN` defined: when the queue is empty and not flushing, `deq_valid` = `enq_valid` and `deq_entry` = `enq_entry` combinationally.
  - If `deq_ready` is also high, the entry bypasses: it is not written, and the pointers and `count` are unchanged.
  - Otherwise the entry is stored normally.
  - Zero-cycle latency on an empty queue.
- Macro undefined: no input-to-output combinational path; one-cycle minimum latency as in Timing.

## Structure
- `lc3b_iqueue_entry` already lives in `lc3b_types`.
- Add `IQUEUE_DEPTH` (default 8) to `lc3b_types` so fetch and dispatch share it.
- No sub-module: pointer, storage and count logic are small enough to live in one module.

## Test plan
- Reset then idle → `enq_ready`=1, `deq_valid`=0, `count`=0.
- Enqueue pc=0x0000..0x000E (8 entries, DEPTH=8) with `deq_ready`=0 → `count`=8, `enq_ready`=0. Then dequeue all 8 → pc order 0x0000,0x0002,…,0x000E, `count` back to 0.
- Streaming 20 entries, with `enq_valid` and `deq_ready` both high every cycle from a partially filled state (3 entries) → pointers wrap twice, `count` stays 3, no entry lost or duplicated.
- Queue holding 5 entries, `flush`=1 with `enq_valid`=1 and `deq_ready`=1 in the same cycle → next cycle `count`=0, `deq_valid`=0, and the flushed-cycle enqueue never appears.
- Full queue, `deq_ready`=1 and `enq_valid`=1 in the same cycle → head leaves, enqueue refused, `count`=7.
- Bypass (macro defined): empty queue, `enq_valid`=1 with pc=0x3000, `deq_ready`=1 → `deq_entry.pc`=0x3000 in the same cycle and `count` stays 0. With the macro undefined → visible the next cycle with `count`=1, then 0 after dequeue.
